// File: rtl/x_deser_pkg.sv
`timescale 1ps/1ps
// x_deser_pkg: shared definitions for the serial-to-parallel deserialiser.
//   state_t   : FSM state encoding (IDLE=0, SHIFT=1)
//   cnt_width : bit-counter width for a given word width
package x_deser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Wide enough to hold 0..WIDTH.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/x_deser_shreg.sv
`timescale 1ps/1ps
// x_deser_shreg: assembly shift register with load-first and direction control.
//   i_clk    : clock, rising edge
//   i_rst    : asynchronous active-high reset, clears the register
//   i_en     : update enable (one serial bit taken)
//   i_load   : start a new word; i_bit becomes bit 0 and the rest is cleared
//   i_bit    : serial data bit
//   o_next   : value the register takes on this edge (the word being completed)
module x_deser_shreg
  import x_deser_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_next
);

  // The first bit enters at the end it travels away from: it must reach
  // O[WIDTH-1] (MSB-first) or O[0] (LSB-first) after WIDTH bits.
  localparam int unsigned ENTRY = MSB_FIRST ? 0 : WIDTH - 1;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_shift_val;

  always_comb begin
    w_load_val        = '0;
    w_load_val[ENTRY] = i_bit;
    w_shift_val       = MSB_FIRST ? {r_q[WIDTH-2:0], i_bit} : {i_bit, r_q[WIDTH-1:1]};
    o_next            = r_q;
    if (i_en) begin
      o_next = i_load ? w_load_val : w_shift_val;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= '0;
    end else begin
      r_q <= o_next;
    end
  end

endmodule

// File: rtl/x_deser_sync.sv
`timescale 1ps/1ps
// x_deser_sync: SYNC-framed serial-to-parallel deserialiser with
// VALID/READY output handshake, sticky overrun and realignment pulse.
//   CLK      : clock, rising edge
//   RST      : asynchronous active-high reset
//   CE       : bit enable; serial bit sampled only when 1
//   I        : serial data
//   SYNC     : marks I as bit 0 of a new word (when CE=1)
//   READY    : consumer accepts O while VALID=1
//   O        : registered parallel word
//   VALID    : O holds an unconsumed word
//   OVR      : sticky overrun (word dropped while O was held)
//   SYNC_ERR : one-cycle pulse when SYNC cut a partial word short
module x_deser_sync
  import x_deser_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             I,
  input  logic             SYNC,
  input  logic             READY,
  output logic [WIDTH-1:0] O,
  output logic             VALID,
  output logic             OVR,
  output logic             SYNC_ERR
);

  localparam int unsigned     CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_sh_en;
  logic             w_sh_load;
  logic             w_done;
  logic             w_serr;
  logic [WIDTH-1:0] w_word;

  logic [WIDTH-1:0] r_o;
  logic             r_valid;
  logic             r_ovr;
  logic             r_serr;

  x_deser_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_en   (w_sh_en),
    .i_load (w_sh_load),
    .i_bit  (I),
    .o_next (w_word)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // cnt==0 in SHIFT means the next bit opens a new word, so it is loaded
  // rather than shifted; SYNC there is legal and raises no error.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sh_en     = 1'b0;
    w_sh_load   = 1'b0;
    w_done      = 1'b0;
    w_serr      = 1'b0;
    if (CE) begin
      case (r_state)
        IDLE: begin
          if (SYNC) begin
            w_sh_en     = 1'b1;
            w_sh_load   = 1'b1;
            w_cnt_nxt   = CW'(1);
            w_state_nxt = SHIFT;
          end
        end
        SHIFT: begin
          w_sh_en = 1'b1;
          if (SYNC || (r_cnt == '0)) begin
            w_sh_load = 1'b1;
            w_cnt_nxt = CW'(1);
            w_serr    = SYNC && (r_cnt != '0);
          end else if (r_cnt == LAST_BIT) begin
            w_done    = 1'b1;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Output handshake: a completed word loads O unless the held word is
  // still unconsumed, in which case it is dropped and OVR latches.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_o     <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_serr  <= 1'b0;
    end else begin
      r_serr <= w_serr;
      if (w_done && (!r_valid || READY)) begin
        r_o     <= w_word;
        r_valid <= 1'b1;
      end else begin
        if (w_done) begin
          r_ovr <= 1'b1;
        end
        if (r_valid && READY) begin
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign O        = r_o;
  assign VALID    = r_valid;
  assign OVR      = r_ovr;
  assign SYNC_ERR = r_serr;

endmodule

// File: tb/tb_x_deser_sync.sv
`timescale 1ps/1ps
module tb_x_deser_sync;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       CE = 1'b0;
  logic       I = 1'b0;
  logic       SYNC = 1'b0;
  logic       READY = 1'b0;

  logic [7:0] O_a, O_b;
  logic       VALID_a, VALID_b, OVR_a, OVR_b, SERR_a, SERR_b;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  logic [7:0]  sb[$];

  always #5 CLK = ~CLK;

  x_deser_sync #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
    .CLK(CLK), .RST(RST), .CE(CE), .I(I), .SYNC(SYNC), .READY(READY),
    .O(O_a), .VALID(VALID_a), .OVR(OVR_a), .SYNC_ERR(SERR_a)
  );

  x_deser_sync #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
    .CLK(CLK), .RST(RST), .CE(CE), .I(I), .SYNC(SYNC), .READY(READY),
    .O(O_b), .VALID(VALID_b), .OVR(OVR_b), .SYNC_ERR(SERR_b)
  );

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives inputs, lets one rising edge pass and
  // returns at the following negedge.
  task automatic step(input logic ce, input logic b, input logic s);
    CE = ce;
    I = b;
    SYNC = s;
    @(negedge CLK);
  endtask

  function automatic logic [7:0] o_of(input bit sel_b);
    return sel_b ? O_b : O_a;
  endfunction
  function automatic logic valid_of(input bit sel_b);
    return sel_b ? VALID_b : VALID_a;
  endfunction
  function automatic logic serr_of(input bit sel_b);
    return sel_b ? SERR_b : SERR_a;
  endfunction

  task automatic pop_check(input bit sel_b);
    logic [7:0] exp;
    if (sb.size() == 0) begin
      n_checks++;
      n_err++;
      $error("FAIL sb_underflow: observed %h expected queued word", o_of(sel_b));
    end else begin
      exp = sb.pop_front();
      check8("word", o_of(sel_b), exp);
    end
  endtask

  // Sends one 8-bit word in the bit order of the selected DUT.
  task automatic send_word(input logic [7:0] w, input bit sync_first, input bit sel_b,
                           input bit gaps, input logic exp_serr,
                           input logic exp_pre_valid, input bit accept);
    for (int k = 0; k < 8; k++) begin
      logic b;
      b = sel_b ? w[k] : w[7-k];
      step(1'b1, b, sync_first && (k == 0));
      if (k == 0) check1("serr_first", serr_of(sel_b), exp_serr);
      if (k == 1) check1("serr_clear", serr_of(sel_b), 1'b0);
      if (k == 6) check1("valid_pre_last", valid_of(sel_b), exp_pre_valid);
      if (gaps && (k != 7)) step(1'b0, ~b, 1'b1);
    end
    if (accept) begin
      check1("valid_done", valid_of(sel_b), 1'b1);
      pop_check(sel_b);
    end
  endtask

  initial begin
    // Reset state
    RST = 1'b1;
    #1;
    check8("rst_O", O_a, 8'h00);
    check1("rst_VALID", VALID_a, 1'b0);
    check1("rst_OVR", OVR_a, 1'b0);
    check1("rst_SERR", SERR_a, 1'b0);
    check8("rst_O_b", O_b, 8'h00);
    @(negedge CLK);
    RST = 1'b0;
    READY = 1'b1;

    // Scenario 1: basic word
    sb.push_back(8'hA5);
    send_word(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check1("s1_valid_clear", VALID_a, 1'b0);
    check8("s1_O_hold", O_a, 8'hA5);

    // Scenario 2: back-to-back
    sb.push_back(8'h3C);
    sb.push_back(8'hC3);
    send_word(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check1("s2_ovr", OVR_a, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check1("s2_valid_clear", VALID_a, 1'b0);

    // Scenario 3: backpressure and overrun (SYNC at cnt=0 is legal)
    READY = 1'b0;
    sb.push_back(8'h11);
    send_word(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check8("s3_O_held", O_a, 8'h11);
    check1("s3_valid", VALID_a, 1'b1);
    check1("s3_ovr", OVR_a, 1'b1);
    READY = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check1("s3_valid_clear", VALID_a, 1'b0);
    check1("s3_ovr_sticky", OVR_a, 1'b1);

    // Scenario 4: realign after 3 bits
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    sb.push_back(8'hF0);
    send_word(8'hF0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Scenario 5: LSB-first with CE gaps (SYNC=1 on CE=0 cycles must be ignored)
    RST = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    RST = 1'b0;
    check1("s5_ovr_reset", OVR_a, 1'b0);
    sb.push_back(8'h5A);
    send_word(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

    // Scenario 6: async reset mid-word
    RST = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    RST = 1'b0;
    READY = 1'b0;
    sb.push_back(8'h96);
    send_word(8'h96, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'h69, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check1("s6_ovr_pre", OVR_a, 1'b1);
    check8("s6_O_pre", O_a, 8'h96);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    check8("s6_O_async", O_a, 8'h00);
    check1("s6_valid_async", VALID_a, 1'b0);
    check1("s6_ovr_async", OVR_a, 1'b0);
    check1("s6_serr_async", SERR_a, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    RST = 1'b0;
    READY = 1'b1;
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b0);
    check1("s6_no_sync_ignored", VALID_a, 1'b0);
    sb.push_back(8'h5C);
    send_word(8'h5C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    check8("sb_drained", 8'(sb.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
